// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the fetch (IF)
// and load/store (DM) stages with a req/ack handshake, stalls and a timeout.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_valid,
  output logic            stall_f,
  output logic            stall_m,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            acc_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] starve_cnt;
  logic          if_pend;
  logic          dm_pend;
  logic          grant_if;
  logic          grant_dm;
  logic          timed_out;
  logic          starved;

  assign stall_f   = if_req & ~if_valid;
  assign stall_m   = dm_req & ~dm_valid;
  assign timed_out = (to_cnt == TW'(TIMEOUT - 1));
  assign starved   = (starve_cnt == SW'(STARVE_LIMIT));

  // Requesters in their valid cycle are retiring and must not be granted again.
  always_comb begin
    if_pend  = if_req & ~if_valid;
    dm_pend  = dm_req & ~dm_valid;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (if_pend && (!dm_pend || starved)) begin
      grant_if = 1'b1;
    end else if (dm_pend) begin
      grant_dm = 1'b1;
    end else begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      acc_err    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      acc_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            to_cnt     <= '0;
            starve_cnt <= '0;
            state      <= BUSY_I;
          end else if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            to_cnt    <= '0;
            state     <= BUSY_D;
            // Only DM grants that overtake a waiting fetch count toward starvation.
            if (if_req) begin
              if (!starved) begin
                starve_cnt <= starve_cnt + SW'(1);
              end
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        BUSY_I: begin
          if (mem_ack || timed_out) begin
            if_rdata <= mem_ack ? mem_rdata : '0;
            if_valid <= 1'b1;
            acc_err  <= ~mem_ack;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        BUSY_D: begin
          if (mem_ack || timed_out) begin
            dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            dm_valid <= 1'b1;
            acc_err  <= ~mem_ack;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and a randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int TIMEOUT = 8;
  localparam int SLIM = 4;
  localparam int NV = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, dm_req, dm_we, mem_ack;
  logic [XLEN-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [XLEN-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic            if_valid, dm_valid, stall_f, stall_m, mem_req, mem_we, acc_err;

  int checks = 0;
  int errors = 0;

  // memory responder controls (written only by the main process)
  int          resp_lat = 0;
  logic [31:0] resp_data = 32'h0;
  bit          use_model = 1'b0;
  bit          rand_lat = 1'b0;
  bit          sim_map = 1'b0;
  int          stray_req = 0;

  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  typedef struct {
    string       name;
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    bit          exp_err;
  } vec_t;

  vec_t vt [NV];

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .acc_err(acc_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Memory model: acks each new mem_req after a programmable wait, optional stray acks.
  initial begin
    int  wait_left;
    int  stray_done;
    bit  prev_req;
    wait_left  = -1;
    stray_done = 0;
    prev_req   = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        mem_ack    = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
      end else if (mem_req) begin
        if (!prev_req) wait_left = rand_lat ? int'($urandom_range(0, 3)) : resp_lat;
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          if (use_model) begin
            if (mem_we) phys_mem[mem_addr] = mem_wdata;
            mem_rdata = mem_we ? 32'hFFFF_FFFF :
                        (phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : init_val(mem_addr));
          end else if (sim_map) begin
            mem_rdata = (mem_addr == 32'h100) ? 32'hDEAD_BEEF : 32'h1234_5678;
          end else begin
            mem_rdata = resp_data;
          end
        end
        wait_left = wait_left - 1;
      end
      prev_req = mem_req;
    end
  end

  initial begin
    int   n, ngr, k, done_cnt, if_age, dm_age, streak;
    bit   got, got_if, got_dm, granted, stall_bad, other_bad, pr, stray_bad, exp_dm;
    bit   if_busy, dm_busy, pi_req, pi_wait, pd_wait, p_ack, p_mreq;
    bit   owner [6];
    logic [31:0] gr [4];
    logic [31:0] exp_d;

    vt[0] = '{"fetch",      1'b0, 1'b0, 32'h0000_0010, 32'h0,          1, 32'h0050_0093, 32'h0050_0093, 4,  1'b0};
    vt[1] = '{"load",       1'b1, 1'b0, 32'h0000_0100, 32'h0,          2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5,  1'b0};
    vt[2] = '{"store",      1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D,  0, 32'h1111_2222, 32'h0,         3,  1'b0};
    vt[3] = '{"fetch_slow", 1'b0, 1'b0, 32'h0000_0ABC, 32'h0,          3, 32'h0BAD_F00D, 32'h0BAD_F00D, 6,  1'b0};
    vt[4] = '{"if_timeout", 1'b0, 1'b0, 32'h0000_0020, 32'h0,         99, 32'h5555_AAAA, 32'h0,         10, 1'b1};
    vt[5] = '{"load_late",  1'b1, 1'b0, 32'h0000_0104, 32'h0,          7, 32'h7777_0007, 32'h7777_0007, 10, 1'b0};
    vt[6] = '{"dm_timeout", 1'b1, 1'b0, 32'h0000_0108, 32'h0,         99, 32'h6666_9999, 32'h0,         10, 1'b1};

    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    chk1("reset.mem_req", mem_req, 1'b0);
    chk1("reset.mem_we", mem_we, 1'b0);
    chk32("reset.mem_addr", mem_addr, 32'h0);
    chk32("reset.mem_wdata", mem_wdata, 32'h0);
    chk1("reset.if_valid", if_valid, 1'b0);
    chk1("reset.dm_valid", dm_valid, 1'b0);
    chk32("reset.if_rdata", if_rdata, 32'h0);
    chk32("reset.dm_rdata", dm_rdata, 32'h0);
    chk1("reset.acc_err", acc_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // table of single transactions
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      resp_lat  = vt[i].lat;
      resp_data = vt[i].mdata;
      if (vt[i].is_dm) begin
        dm_req = 1'b1; dm_we = vt[i].we; dm_addr = vt[i].addr; dm_wdata = vt[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vt[i].addr;
      end
      n = 0; got = 1'b0; granted = 1'b0; stall_bad = 1'b0; other_bad = 1'b0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        if (mem_req && !granted) begin
          granted = 1'b1;
          chk32($sformatf("%s.grant_cyc", vt[i].name), n, 32'd2);
          chk32($sformatf("%s.mem_addr", vt[i].name), mem_addr, vt[i].addr);
          chk1($sformatf("%s.mem_we", vt[i].name), mem_we, vt[i].we);
          if (vt[i].is_dm && vt[i].we) chk32($sformatf("%s.mem_wdata", vt[i].name), mem_wdata, vt[i].wdata);
        end
        if (vt[i].is_dm ? if_valid : dm_valid) other_bad = 1'b1;
        if (vt[i].is_dm ? dm_valid : if_valid) got = 1'b1;
        else if ((vt[i].is_dm ? stall_m : stall_f) !== 1'b1) stall_bad = 1'b1;
      end
      chk1($sformatf("%s.valid_seen", vt[i].name), got, 1'b1);
      chk32($sformatf("%s.latency", vt[i].name), n, vt[i].exp_cyc);
      chk32($sformatf("%s.rdata", vt[i].name), vt[i].is_dm ? dm_rdata : if_rdata, vt[i].exp_rdata);
      chk1($sformatf("%s.acc_err", vt[i].name), acc_err, vt[i].exp_err);
      chk1($sformatf("%s.mem_req_drop", vt[i].name), mem_req, 1'b0);
      chk1($sformatf("%s.stall_at_valid", vt[i].name), vt[i].is_dm ? stall_m : stall_f, 1'b0);
      chk1($sformatf("%s.stall_held", vt[i].name), stall_bad, 1'b0);
      chk1($sformatf("%s.other_quiet", vt[i].name), other_bad, 1'b0);
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0;
      repeat (2) @(posedge clk);
    end

    // stray ack after the DM timeout is ignored
    @(posedge clk); #1;
    stray_req++;
    stray_bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dm_valid || if_valid || acc_err || mem_req) stray_bad = 1'b1;
    end
    chk1("stray.ignored", stray_bad, 1'b0);
    chk32("stray.dm_rdata_held", dm_rdata, 32'h0);

    // simultaneous IF and DM requests: DM first, no re-grant in its valid cycle
    @(posedge clk); #1;
    resp_lat = 0; sim_map = 1'b1;
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    ngr = 0; got_if = 1'b0; got_dm = 1'b0; pr = 1'b0;
    for (int c = 0; c < 20 && !(got_if && got_dm); c++) begin
      @(negedge clk);
      if (mem_req && !pr) begin
        if (ngr < 4) gr[ngr] = mem_addr;
        ngr++;
      end
      pr = mem_req;
      if (dm_valid) begin
        chk1("sim.dm_before_if", got_if, 1'b0);
        chk32("sim.dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        got_dm = 1'b1;
      end
      if (if_valid) begin
        chk32("sim.if_rdata", if_rdata, 32'h1234_5678);
        got_if = 1'b1;
      end
      @(posedge clk); #1;
      if (got_dm) dm_req = 1'b0;
      if (got_if) if_req = 1'b0;
    end
    chk1("sim.dm_done", got_dm, 1'b1);
    chk1("sim.if_done", got_if, 1'b1);
    chk32("sim.grant_count", ngr, 32'd2);
    chk32("sim.first_grant", gr[0], 32'h100);
    chk32("sim.second_grant", gr[1], 32'h10);
    sim_map = 1'b0;
    repeat (2) @(posedge clk);

    // IF held and DM re-requesting back to back: IF must not be starved
    #1;
    resp_lat = 0; resp_data = 32'h0000_0013;
    if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    ngr = 0; pr = 1'b0;
    for (int c = 0; c < 80 && ngr < 6; c++) begin
      @(negedge clk);
      if (mem_req && !pr) begin
        owner[ngr] = (mem_addr >= 32'h300);
        ngr++;
      end
      pr = mem_req;
      got_dm = dm_valid; got_if = if_valid;
      @(posedge clk); #1;
      if (got_dm) dm_addr = dm_addr + 32'h4;
      if (got_if) if_addr = if_addr + 32'h4;
    end
    chk32("starve.grants", ngr, 32'd6);
    k = 6;
    for (int j = 5; j >= 0; j--) if (!owner[j]) k = j;
    chk1("starve.if_within_limit", k <= SLIM, 1'b1);
    if (k < 5) chk1("starve.dm_after_if", owner[k+1], 1'b1);
    // requester drops mid-access: the access still completes
    if_req = 1'b0; dm_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (owner[5] ? dm_valid : if_valid) got = 1'b1;
    end
    chk1("drop.valid_still", got, 1'b1);
    repeat (2) @(posedge clk);

    // reset in the middle of a fetch
    #1;
    resp_lat = 99; if_req = 1'b1; if_addr = 32'h80;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (mem_req) got = 1'b1;
    end
    chk1("rstmid.granted", got, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; resp_lat = 0; resp_data = 32'h0000_0297;
    @(negedge clk);
    chk1("rstmid.mem_req", mem_req, 1'b0);
    chk1("rstmid.if_valid", if_valid, 1'b0);
    chk1("rstmid.acc_err", acc_err, 1'b0);
    n = 0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      n++;
      if (if_valid) got = 1'b1;
    end
    chk1("rstmid.regrant_valid", got, 1'b1);
    chk32("rstmid.regrant_latency", n, 32'd2);
    chk32("rstmid.if_rdata", if_rdata, 32'h0000_0297);
    @(posedge clk); #1;
    if_req = 1'b0;

    // randomized traffic against a transaction-level model
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; use_model = 1'b1; rand_lat = 1'b1;
    if_busy = 1'b0; dm_busy = 1'b0; streak = 0; done_cnt = 0; if_age = 0; dm_age = 0;
    pi_req = 1'b0; pi_wait = 1'b0; pd_wait = 1'b0; p_ack = 1'b0; p_mreq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk1("rnd.stall_f", stall_f, if_req & ~if_valid);
      chk1("rnd.stall_m", stall_m, dm_req & ~dm_valid);
      if (mem_req && !p_mreq) begin
        exp_dm = pd_wait && !(streak == SLIM && pi_wait);
        chk1("rnd.grant_owner", mem_addr[31], exp_dm);
        if (mem_addr[31]) begin
          chk1("rnd.grant_dm_busy", dm_busy, 1'b1);
          chk32("rnd.dm_addr", mem_addr, dm_addr);
          chk1("rnd.dm_we", mem_we, dm_we);
          if (dm_we) chk32("rnd.dm_wdata", mem_wdata, dm_wdata);
          streak = pi_req ? ((streak < SLIM) ? streak + 1 : SLIM) : 0;
        end else begin
          chk1("rnd.grant_if_busy", if_busy, 1'b1);
          chk32("rnd.if_addr", mem_addr, if_addr);
          chk1("rnd.if_we", mem_we, 1'b0);
          streak = 0;
        end
      end
      if (p_ack) chk1("rnd.ack_to_valid", if_valid | dm_valid, 1'b1);
      if (if_valid) begin
        chk1("rnd.if_pending", if_busy, 1'b1);
        chk1("rnd.if_acked", p_ack, 1'b1);
        chk32("rnd.if_rdata", if_rdata, init_val(if_addr));
        chk1("rnd.if_latency", if_age < 60, 1'b1);
        if_busy = 1'b0; done_cnt++;
      end
      if (dm_valid) begin
        chk1("rnd.dm_pending", dm_busy, 1'b1);
        chk1("rnd.dm_acked", p_ack, 1'b1);
        exp_d = dm_we ? 32'h0 : ref_read(dm_addr);
        chk32("rnd.dm_rdata", dm_rdata, exp_d);
        chk1("rnd.dm_latency", dm_age < 60, 1'b1);
        if (dm_we) ref_mem[dm_addr] = dm_wdata;
        dm_busy = 1'b0; done_cnt++;
      end
      if (if_valid || dm_valid) chk1("rnd.acc_err", acc_err, 1'b0);
      pi_req = if_req; pi_wait = if_req & ~if_valid; pd_wait = dm_req & ~dm_valid;
      p_ack = mem_ack; p_mreq = mem_req;
      if_age = if_busy ? if_age + 1 : 0;
      dm_age = dm_busy ? dm_age + 1 : 0;
      @(posedge clk); #1;
      if (!if_busy) begin
        if ($urandom_range(0, 2) != 0) begin
          if_busy = 1'b1; if_req = 1'b1;
          if_addr = {16'h0000, 14'($urandom), 2'b00};
        end else begin
          if_req = 1'b0;
        end
      end
      if (!dm_busy) begin
        if ($urandom_range(0, 2) != 0) begin
          dm_busy = 1'b1; dm_req = 1'b1;
          dm_we = 1'($urandom_range(0, 1));
          dm_addr = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
          dm_wdata = $urandom;
        end else begin
          dm_req = 1'b0;
        end
      end
    end
    chk1("rnd.progress", done_cnt > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters in the 5-stage RISC-V pipeline: the fetch stage (IF) and the memory stage (load/store, DM).
- Serializes accesses with a req/ack handshake to memory and returns read data to the owning requester.
- Generates stall signals for IF and MEM until each access completes.
- Detects memory timeouts.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack in a busy state; counter width is clog2(TIMEOUT+1).
- STARVE_LIMIT, 4, maximum consecutive DM grants while if_req is pending before IF is forced a grant.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  XLEN  fetch address (PC)
- if_rdata  out  XLEN  fetched instruction
- if_valid  out  1  one-cycle pulse; if_rdata valid
- dm_req  in  1  data request (load or store); held high until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  XLEN  data address (ALU result)
- dm_wdata  in  XLEN  store data
- dm_rdata  out  XLEN  load data
- dm_valid  out  1  one-cycle pulse; access complete
- stall_f  out  1  IF/ID stall: if_req & ~if_valid (combinational)
- stall_m  out  1  whole-pipe stall: dm_req & ~dm_valid (combinational)
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  XLEN  memory address, registered
- mem_wdata  out  XLEN  memory write data, registered
- mem_rdata  in  XLEN  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, single-cycle
- acc_err  out  1  one-cycle pulse on timeout, coincident with the owner's valid

Behaviour:
- Interface: single clock clk; synchronous active-high reset rst.
- Reset values: state = IDLE; all outputs 0; starve counter 0; timeout counter 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - A requester whose valid is high this cycle is masked. This prevents re-granting a request being retired.
  - DM wins over IF, because DM holds the older instruction.
  - Exception: if the starve count equals STARVE_LIMIT and if_req is high, IF wins.
- On grant:
  - Latch address (and for DM: we, wdata) into the mem_* registers.
  - Set mem_req = 1.
  - Go to BUSY_I or BUSY_D.
  - Clear the timeout counter.
- BUSY_x, mem_ack = 1:
  - Capture mem_rdata into the owner's rdata register. For a store, dm_rdata is written 0.
  - Pulse the owner's valid next cycle.
  - Drop mem_req.
  - Return to IDLE.
- BUSY_x, no ack:
  - Increment the timeout counter.
  - When the count reaches TIMEOUT, treat as complete: rdata = 0, valid and acc_err pulse, mem_req drops, go to IDLE.
  - A late mem_ack in IDLE is ignored.
- Latency: a request seen in IDLE at cycle t gives mem_req at t+1. mem_ack at cycle a gives valid at a+1. Minimum is 3 cycles from request to valid with zero-wait memory.
- Starve counter:
  - Increments on each DM grant made while if_req is high, saturating at STARVE_LIMIT.
  - Clears on any IF grant, or when a DM grant is made with if_req low.
- mem_* outputs hold their values while busy. mem_addr, mem_we and mem_wdata keep their last values in IDLE; only mem_req qualifies them.
- A requester that drops its req mid-transaction does not abort the access. The access completes and valid still pulses.
- Simultaneous new requests while BUSY are held off; stall_f and stall_m remain high.
- rst asserted mid-transaction: the next cycle shows state IDLE and mem_req = 0, and no valid is produced for the aborted access.
- The rdata registers update only on completion and hold their value otherwise.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010, memory acks 1 cycle after mem_req with 0x00500093 -> mem_addr=0x10, mem_we=0; if_valid pulses one cycle later with if_rdata=0x00500093; stall_f high until then.
- Simultaneous requests:
  - Stimulus: if_req and dm_req both high; dm is a load at addr 0x100; memory returns 0xDEADBEEF then 0x12345678.
  - Required: DM is served first, dm_valid with 0xDEADBEEF; then IF is served with if_valid and 0x12345678.
  - Required: no re-grant of DM in its valid cycle.
- Store: dm_req=1, dm_we=1, addr 0x200, wdata 0xCAFEF00D -> mem_we=1, mem_wdata=0xCAFEF00D; dm_valid pulses with dm_rdata=0.
- Starvation:
  - Stimulus: if_req held high; dm_req reasserted immediately after every dm_valid.
  - Required: after 4 consecutive DM grants, the 5th grant goes to IF; the starve counter then clears.
- Timeout: TIMEOUT=8, dm_req, no mem_ack -> mem_req drops after 8 busy cycles; dm_valid and acc_err pulse together with dm_rdata=0; a later stray mem_ack is ignored.
- Reset mid-access: rst pulsed while in BUSY_I -> next cycle mem_req=0, if_valid=0, state IDLE; a fresh if_req is then granted normally.
